lcd_bus_responder: RTL
======================

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40: clk cycles busy after a normal write.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600: clk cycles busy after clear or return-home.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port lcd_e, input, 1: bus enable, asynchronous to clk.
REQ-006 SHALL have port lcd_rs, input, 1: 0 = instruction/status, 1 = data.
REQ-007 SHALL have port lcd_rw, input, 1: 0 = write, 1 = read.
REQ-008 SHALL have port lcd_db_in, input, 8: bus data from the writer.
REQ-009 SHALL have port lcd_db_out, output, 8: read-back data.
REQ-010 SHALL have port lcd_db_oe, output, 1: high while driving read data.
REQ-011 SHALL have port busy, output, 1: busy flag.
REQ-012 SHALL have port cmd_valid, output, 1: one-cycle pulse per executed byte.
REQ-013 SHALL have port cmd_rs, output, 1, and port cmd_byte, output, 8: RS and byte of the last executed transfer.
REQ-014 SHALL have port err_busy_wr, output, 1: one-cycle pulse when a write arrives while busy.
REQ-015 SHALL have port mon_addr, input, 5, and port mon_char, output, 8: checker port (0-15 row 0, 16-31 row 1), registered, 1-cycle latency.

Function
REQ-016 SHALL synchronize lcd_e through 2 flops and pipeline lcd_rs, lcd_rw and lcd_db_in through matching stages so the values sampled on an E falling edge belong to that edge.
REQ-017 SHALL act on a transfer one clk after the synchronized falling edge of E; cmd_valid SHALL assert on that cycle.
REQ-018 SHALL drop a write (RW=0) arriving while busy=1, pulse err_busy_wr, and leave all state unchanged.
REQ-019 SHALL hold a 7-bit address counter AC; bit 6 selects the row and bits 3:0 select the column; bits 5:4 are ignored.
REQ-020 SHALL wrap AC on increment 0x0F->0x40 and 0x4F->0x00, and on decrement 0x00->0x4F and 0x40->0x0F.
REQ-021 SHALL decode instruction writes by their highest set bit:
- 0x01 clear: fill DDRAM with 0x20, AC=0, I/D=1, busy CLEAR_CYCLES.
- 0x02-0x03 home: AC=0, busy CLEAR_CYCLES.
- 0x04-0x07 entry mode: store I/D (bit 1); S ignored.
- 0x08-0x0F display control: store D, C, B in disp_ctrl[2:0].
- 0x10-0x1F shift: when S/C=0, move AC by R/L (bit 2); when S/C=1, no AC change.
- 0x20-0x3F function set: store N and F; DL per REQ-030.
- 0x40-0x7F CGRAM address: no effect except busy.
- 0x80-0xFF: AC = byte[6:0].
REQ-022 SHALL give every non-clear, non-home instruction a busy time of BUSY_CYCLES.
REQ-023 SHALL, on a data write (RS=1, RW=0), store the byte to DDRAM[AC], step AC by I/D, and set busy for BUSY_CYCLES.
REQ-024 SHALL, while synchronized E=1 and RW=1, drive lcd_db_oe=1 and lcd_db_out as follows:
- RS=0: {busy, AC}.
- RS=1: DDRAM[AC], with AC stepping on the falling edge.
REQ-025 SHALL accept reads even while busy.
REQ-026 SHALL keep busy=1 exactly from the cycle after acceptance for the programmed count, then return it to 0.
REQ-027 SHALL serve mon_char at any time, independent of bus activity; a write and a monitor read to the same address in the same cycle SHALL return the old value.

Reset
REQ-028 SHALL, on rst, asynchronously clear:
- AC=0, I/D=1, disp_ctrl=0, busy counter=0.
- All outputs to 0.
- DDRAM to 0x20.
- Synchronizer and pipeline flops to 0.
- Nibble phase to high.
REQ-029 SHALL abort any pending busy period or half-received nibble pair on rst, with no cmd_valid afterwards.

Configuration
REQ-030 SHALL, with LCD_RESP_4BIT_EN defined, support 4-bit mode:
- Function set with DL=0 selects 4-bit mode; DL=1 selects 8-bit mode.
- In 4-bit mode each E falling edge captures lcd_db_in[7:4], high nibble first.
- The byte executes on the second nibble, using RS/RW from the first nibble.
- The busy check applies at the first nibble.
- Reads return the high nibble, then the low nibble, on lcd_db_out[7:4].
REQ-031 SHALL, without LCD_RESP_4BIT_EN, ignore DL and operate in 8-bit mode only.

Verification
REQ-032 SHALL cover: reset, then write data 0x41 at AC=0 -> mon_addr=0 returns 0x41; AC=1; busy high for 40 cycles.
REQ-033 SHALL cover: write 0x8F, then data 0x42 -> 0x42 at index 15; AC=0x40.
REQ-034 SHALL cover: clear 0x01 followed by data 0x43 after 10 cycles -> err_busy_wr pulse; 0x43 not stored; all 32 cells read 0x20.
REQ-035 SHALL cover: entry 0x04 (decrement), AC=0, data 0x44 -> 0x44 at index 0; AC=0x4F.
REQ-036 SHALL cover: status read after data write while busy -> lcd_db_out=0x81, lcd_db_oe=1 only while E high.
REQ-037 SHALL cover, with LCD_RESP_4BIT_EN: 0x2 nibble, then nibbles 4 and 1 with RS=1 -> 0x41 stored, one cmd_valid per byte.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus slave: DDRAM, address counter, busy timing and a checker port.
// Define LCD_RESP_4BIT_EN to add 4-bit (nibble) bus mode selected by the function-set DL bit.
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db_in,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       err_busy_wr,
  input  logic [4:0] mon_addr,
  output logic [7:0] mon_char
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // Stage 1/2 synchronize E; stage 3 holds the last value seen with E high,
  // so a detected fall uses bus values captured while E was still asserted.
  logic [2:0]      e_sync;
  logic [2:0]      rs_pipe;
  logic [2:0]      rw_pipe;
  logic [2:0][7:0] db_pipe;

  logic       fall;
  logic       rd_en;
  logic       s_rs;
  logic       s_rw;
  logic [7:0] s_db;

  logic [6:0]    ac, ac_n;
  logic          id, id_n;
  logic [2:0]    disp_ctrl, disp_n;
  logic [1:0]    func_nf, nf_n;
  logic [CW-1:0] busy_cnt, cnt_n;
  logic [7:0]    ddram [32];
  logic [4:0]    ac_idx;

  logic       go;
  logic       x_rs;
  logic       x_rw;
  logic [7:0] x_byte;
  logic       wr_en;
  logic       clr_all;
  logic       valid_n;
  logic       err_n;
  logic       crs_n;
  logic [7:0] cbyte_n;
  logic [7:0] rd_val;
  logic [7:0] rd_drive;

`ifdef LCD_RESP_4BIT_EN
  logic       mode_4bit, mode_n;
  logic       nib_hi, nib_hi_n;
  logic       nib_rs, nib_rs_n;
  logic       nib_rw, nib_rw_n;
  logic [3:0] nib_data, nib_data_n;
`endif

  // Row/column stepping: the 16-column rows are chained into one 32-cell ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) r = (a[3:0] == 4'hF) ? {~a[6], a[5:4], 4'h0} : {a[6:4], a[3:0] + 4'h1};
    else    r = (a[3:0] == 4'h0) ? {~a[6], a[5:4], 4'hF} : {a[6:4], a[3:0] - 4'h1};
    return r;
  endfunction

  assign fall   = e_sync[2] & ~e_sync[1];
  assign rd_en  = e_sync[1] & rw_pipe[1];
  assign s_rs   = rs_pipe[2];
  assign s_rw   = rw_pipe[2];
  assign s_db   = db_pipe[2];
  assign busy   = (busy_cnt != '0);
  assign ac_idx = {ac[6], ac[3:0]};
  assign rd_val = rs_pipe[1] ? ddram[ac_idx] : {busy, ac};

`ifdef LCD_RESP_4BIT_EN
  assign rd_drive = !mode_4bit ? rd_val :
                    nib_hi     ? {rd_val[7:4], 4'h0} : {rd_val[3:0], 4'h0};
`else
  assign rd_drive = rd_val;
`endif

  always_comb begin
    ac_n    = ac;
    id_n    = id;
    disp_n  = disp_ctrl;
    nf_n    = func_nf;
    cnt_n   = busy ? busy_cnt - CW'(1) : '0;
    wr_en   = 1'b0;
    clr_all = 1'b0;
    valid_n = 1'b0;
    err_n   = 1'b0;
    crs_n   = cmd_rs;
    cbyte_n = cmd_byte;
    go      = 1'b0;
    x_rs    = s_rs;
    x_rw    = s_rw;
    x_byte  = s_db;
`ifdef LCD_RESP_4BIT_EN
    mode_n     = mode_4bit;
    nib_hi_n   = nib_hi;
    nib_rs_n   = nib_rs;
    nib_rw_n   = nib_rw;
    nib_data_n = nib_data;
`endif

    if (fall) begin
`ifdef LCD_RESP_4BIT_EN
      if (mode_4bit && nib_hi) begin
        if (!s_rw && busy) begin
          err_n = 1'b1;
        end else begin
          nib_hi_n   = 1'b0;
          nib_rs_n   = s_rs;
          nib_rw_n   = s_rw;
          nib_data_n = s_db[7:4];
        end
      end else if (mode_4bit) begin
        go       = 1'b1;
        nib_hi_n = 1'b1;
        x_rs     = nib_rs;
        x_rw     = nib_rw;
        x_byte   = {nib_data, s_db[7:4]};
      end else
`endif
      if (!s_rw && busy) err_n = 1'b1;
      else               go    = 1'b1;
    end

    if (go) begin
      if (x_rw) begin
        if (x_rs) ac_n = ac_step(ac, id);
      end else begin
        valid_n = 1'b1;
        crs_n   = x_rs;
        cbyte_n = x_byte;
        cnt_n   = CW'(BUSY_CYCLES);
        if (x_rs) begin
          wr_en = 1'b1;
          ac_n  = ac_step(ac, id);
        end else begin
          casez (x_byte)
            8'b1???????: ac_n = x_byte[6:0];
            8'b01??????: ;
            8'b001?????: begin
              nf_n = x_byte[3:2];
`ifdef LCD_RESP_4BIT_EN
              mode_n = ~x_byte[4];
`endif
            end
            8'b0001????: if (!x_byte[3]) ac_n = ac_step(ac, x_byte[2]);
            8'b00001???: disp_n = x_byte[2:0];
            8'b000001??: id_n = x_byte[1];
            8'b0000001?: begin
              ac_n  = '0;
              cnt_n = CW'(CLEAR_CYCLES);
            end
            8'b00000001: begin
              ac_n    = '0;
              id_n    = 1'b1;
              clr_all = 1'b1;
              cnt_n   = CW'(CLEAR_CYCLES);
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sync      <= '0;
      rs_pipe     <= '0;
      rw_pipe     <= '0;
      db_pipe     <= '0;
      ac          <= '0;
      id          <= 1'b1;
      disp_ctrl   <= '0;
      func_nf     <= '0;
      busy_cnt    <= '0;
      cmd_valid   <= 1'b0;
      cmd_rs      <= 1'b0;
      cmd_byte    <= '0;
      err_busy_wr <= 1'b0;
      lcd_db_oe   <= 1'b0;
      lcd_db_out  <= '0;
    end else begin
      e_sync      <= {e_sync[1:0], lcd_e};
      rs_pipe     <= {rs_pipe[1:0], lcd_rs};
      rw_pipe     <= {rw_pipe[1:0], lcd_rw};
      db_pipe     <= {db_pipe[1:0], lcd_db_in};
      ac          <= ac_n;
      id          <= id_n;
      disp_ctrl   <= disp_n;
      func_nf     <= nf_n;
      busy_cnt    <= cnt_n;
      cmd_valid   <= valid_n;
      cmd_rs      <= crs_n;
      cmd_byte    <= cbyte_n;
      err_busy_wr <= err_n;
      lcd_db_oe   <= rd_en;
      lcd_db_out  <= rd_en ? rd_drive : 8'h00;
    end
  end

`ifdef LCD_RESP_4BIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_4bit <= 1'b0;
      nib_hi    <= 1'b1;
      nib_rs    <= 1'b0;
      nib_rw    <= 1'b0;
      nib_data  <= '0;
    end else begin
      mode_4bit <= mode_n;
      nib_hi    <= nib_hi_n;
      nib_rs    <= nib_rs_n;
      nib_rw    <= nib_rw_n;
      nib_data  <= nib_data_n;
    end
  end
`endif

  // The monitor read samples the array before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      mon_char <= '0;
    end else begin
      if (clr_all) begin
        for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      end else if (wr_en) begin
        ddram[ac_idx] <= x_byte;
      end
      mon_char <= ddram[mon_addr];
    end
  end

endmodule
